// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin arbiter for the shared system bus, with an abort path and a grant watchdog.
// Revision 1.0 - initial release.
`default_nettype none

module bus_arbiter #(
  parameter int MASTER_NUM = 4,
  parameter int CORE_IDX   = 0,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [MASTER_NUM-1:0] req_i,
  input  logic                  done_i,
  output logic [MASTER_NUM-1:0] grant_o,
  output logic [2:0]            grant_id_o,
  output logic                  busy_o,
  output logic                  hold_flag_o,
  output logic                  timeout_o
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t      state;
  logic [2:0]  last;
  logic [15:0] cnt;
  logic [2:0]  sel;
  logic        granted_req;

  // Masters above the last winner take precedence over those at or below it.
  // Descending loops leave the lowest matching index in sel.
  always_comb begin
    sel = '0;
    for (int i = MASTER_NUM - 1; i >= 0; i--) begin
      if (req_i[i] && (i <= int'(last))) sel = 3'(i);
    end
    for (int i = MASTER_NUM - 1; i >= 0; i--) begin
      if (req_i[i] && (i > int'(last))) sel = 3'(i);
    end
  end

  // grant_o is one-hot, so this is the request bit of the current owner.
  assign granted_req = |(req_i & grant_o);
  assign hold_flag_o = req_i[CORE_IDX] & ~grant_o[CORE_IDX];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      grant_o    <= '0;
      grant_id_o <= '0;
      busy_o     <= 1'b0;
      timeout_o  <= 1'b0;
      cnt        <= '0;
      last       <= 3'(MASTER_NUM - 1);
    end else begin
      timeout_o <= 1'b0;
      case (state)
        IDLE: begin
          if (req_i != '0) begin
            grant_o    <= MASTER_NUM'(1) << sel;
            grant_id_o <= sel;
            busy_o     <= 1'b1;
            last       <= sel;
            cnt        <= '0;
            state      <= BUSY;
          end
        end
        BUSY: begin
          if (done_i || !granted_req) begin
            grant_o <= '0;
            busy_o  <= 1'b0;
            state   <= IDLE;
          end else if (cnt == 16'(TIMEOUT - 1)) begin
            grant_o   <= '0;
            busy_o    <= 1'b0;
            timeout_o <= 1'b1;
            state     <= IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: begin
          grant_o <= '0;
          busy_o  <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: scenario tasks for bus_arbiter; expected grant ids are queued at stimulus time.
`default_nettype none

module tb_bus_arbiter;
  localparam int MN = 4;

  logic          clk;
  logic          rst;
  logic [MN-1:0] req_i;
  logic          done_i;
  logic [MN-1:0] grant_o;
  logic [2:0]    grant_id_o;
  logic          busy_o;
  logic          hold_flag_o;
  logic          timeout_o;

  int checks = 0;
  int passed = 0;
  int exp_q[$];

  bus_arbiter #(.MASTER_NUM(MN), .CORE_IDX(0), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .done_i(done_i),
    .grant_o(grant_o), .grant_id_o(grant_id_o), .busy_o(busy_o),
    .hold_flag_o(hold_flag_o), .timeout_o(timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_busy(output int cycles);
    cycles = 0;
    while (!busy_o && cycles < 20) begin
      step();
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; req_i = 4'b0001; done_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({grant_o, grant_id_o, busy_o, timeout_o, hold_flag_o} !== {4'b0, 3'b0, 1'b0, 1'b0, 1'b1}) begin
        $display("FAIL reset_outputs cyc%0d: got grant=%b id=%0d busy=%b to=%b hold=%b want 0000/0/0/0/1",
                 i, grant_o, grant_id_o, busy_o, timeout_o, hold_flag_o);
      end else passed++;
    end
    rst = 1'b1;
    step();
    checks++;
    if (grant_o !== 4'b0001 || hold_flag_o !== 1'b0) begin
      $display("FAIL reset_first_grant: got grant=%b hold=%b want 0001/0", grant_o, hold_flag_o);
    end else passed++;
    done_i = 1'b1; step(); done_i = 1'b0; req_i = '0;
    // done_i in IDLE must be ignored
    done_i = 1'b1; step(); done_i = 1'b0;
    step();
    checks++;
    if (busy_o !== 1'b0 || grant_o !== 4'b0) begin
      $display("FAIL idle_done_ignored: got busy=%b grant=%b want 0/0000", busy_o, grant_o);
    end else passed++;
  endtask

  task automatic test_round_robin();
    int cyc;
    int e;
    rst = 1'b0; step(); rst = 1'b1;
    req_i = 4'b1111;
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
    exp_q.push_back(3); exp_q.push_back(0);
    for (int k = 0; k < 5; k++) begin
      wait_busy(cyc);
      e = exp_q.pop_front();
      checks++;
      if (cyc !== 1 || int'(grant_id_o) !== e || grant_o !== 4'(1 << e)) begin
        $display("FAIL rr_grant%0d: got id=%0d grant=%b after %0d cyc want id=%0d after 1 cyc",
                 k, grant_id_o, grant_o, cyc, e);
      end else passed++;
      step();
      done_i = 1'b1; step(); done_i = 1'b0;
      if (k == 4) req_i = '0;
      checks++;
      if (busy_o !== 1'b0 || grant_o !== 4'b0) begin
        $display("FAIL rr_idle_gap%0d: got busy=%b grant=%b want 0/0000", k, busy_o, grant_o);
      end else passed++;
    end
    step();
  endtask

  task automatic test_core_stall();
    int cyc;
    int e;
    req_i = 4'b0100;
    exp_q.push_back(2);
    wait_busy(cyc);
    e = exp_q.pop_front();
    checks++;
    if (int'(grant_id_o) !== e || grant_o !== 4'b0100) begin
      $display("FAIL stall_grant2: got id=%0d grant=%b want id=%0d grant=0100", grant_id_o, grant_o, e);
    end else passed++;
    req_i = 4'b0101; #1;
    checks++;
    if (hold_flag_o !== 1'b1) $display("FAIL stall_hold_rise: got hold=%b want 1", hold_flag_o);
    else passed++;
    step();
    checks++;
    if (hold_flag_o !== 1'b1) $display("FAIL stall_hold_busy: got hold=%b want 1", hold_flag_o);
    else passed++;
    done_i = 1'b1; step(); done_i = 1'b0;
    req_i = 4'b0001;
    exp_q.push_back(0);
    #1;
    checks++;
    if (hold_flag_o !== 1'b1 || busy_o !== 1'b0) begin
      $display("FAIL stall_idle_cycle: got hold=%b busy=%b want 1/0", hold_flag_o, busy_o);
    end else passed++;
    step();
    e = exp_q.pop_front();
    checks++;
    if (grant_o !== 4'(1 << e) || hold_flag_o !== 1'b0) begin
      $display("FAIL stall_core_grant: got grant=%b hold=%b want %b/0", grant_o, hold_flag_o, 4'(1 << e));
    end else passed++;
    done_i = 1'b1; step(); done_i = 1'b0; req_i = '0;
    step();
  endtask

  task automatic test_abort();
    int cyc;
    int e;
    req_i = 4'b0110;
    exp_q.push_back(1);
    wait_busy(cyc);
    e = exp_q.pop_front();
    checks++;
    if (int'(grant_id_o) !== e) $display("FAIL abort_grant1: got id=%0d want %0d", grant_id_o, e);
    else passed++;
    step(); step();
    req_i = 4'b0100;
    exp_q.push_back(2);
    step();
    checks++;
    if (grant_o !== 4'b0 || busy_o !== 1'b0 || timeout_o !== 1'b0) begin
      $display("FAIL abort_release: got grant=%b busy=%b to=%b want 0000/0/0", grant_o, busy_o, timeout_o);
    end else passed++;
    step();
    e = exp_q.pop_front();
    checks++;
    if (int'(grant_id_o) !== e || grant_o !== 4'b0100) begin
      $display("FAIL abort_next_grant: got id=%0d grant=%b want id=%0d grant=0100", grant_id_o, grant_o, e);
    end else passed++;
    done_i = 1'b1; step(); done_i = 1'b0; req_i = '0;
    step();
  endtask

  task automatic test_timeout();
    int cyc;
    int e;
    req_i = 4'b1000;
    exp_q.push_back(3);
    wait_busy(cyc);
    e = exp_q.pop_front();
    checks++;
    if (int'(grant_id_o) !== e) $display("FAIL to_grant3: got id=%0d want %0d", grant_id_o, e);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (timeout_o !== 1'b0 || busy_o !== 1'b1) begin
        $display("FAIL to_early%0d: got to=%b busy=%b want 0/1", i, timeout_o, busy_o);
      end else passed++;
    end
    step();
    checks++;
    if (timeout_o !== 1'b1 || grant_o !== 4'b0) begin
      $display("FAIL to_fire: got to=%b grant=%b want 1/0000", timeout_o, grant_o);
    end else passed++;
    exp_q.push_back(3);
    step();
    e = exp_q.pop_front();
    checks++;
    if (timeout_o !== 1'b0 || int'(grant_id_o) !== e || busy_o !== 1'b1) begin
      $display("FAIL to_pulse_regrant: got to=%b id=%0d busy=%b want 0/%0d/1", timeout_o, grant_id_o, busy_o, e);
    end else passed++;
    step(); step(); step();
    done_i = 1'b1; step(); done_i = 1'b0; req_i = '0;
    checks++;
    if (timeout_o !== 1'b0 || busy_o !== 1'b0) begin
      $display("FAIL to_done_wins: got to=%b busy=%b want 0/0", timeout_o, busy_o);
    end else passed++;
    step();
  endtask

  task automatic test_mid_reset();
    int cyc;
    int e;
    req_i = 4'b0010;
    exp_q.push_back(1);
    wait_busy(cyc);
    e = exp_q.pop_front();
    checks++;
    if (int'(grant_id_o) !== e) $display("FAIL mr_grant1: got id=%0d want %0d", grant_id_o, e);
    else passed++;
    step();
    rst = 1'b0;
    step();
    checks++;
    if (grant_o !== 4'b0 || busy_o !== 1'b0 || timeout_o !== 1'b0) begin
      $display("FAIL mr_drop: got grant=%b busy=%b to=%b want 0000/0/0", grant_o, busy_o, timeout_o);
    end else passed++;
    req_i = 4'b0011; #1;
    checks++;
    if (hold_flag_o !== 1'b1) $display("FAIL mr_hold: got hold=%b want 1", hold_flag_o);
    else passed++;
    step();
    rst = 1'b1;
    exp_q.push_back(0);
    step();
    e = exp_q.pop_front();
    checks++;
    if (int'(grant_id_o) !== e || grant_o !== 4'b0001 || busy_o !== 1'b1) begin
      $display("FAIL mr_first_grant: got id=%0d grant=%b busy=%b want %0d/0001/1", grant_id_o, grant_o, busy_o, e);
    end else passed++;
    done_i = 1'b1; step(); done_i = 1'b0; req_i = '0;
    step();
  endtask

  initial begin
    rst = 1'b0; req_i = '0; done_i = 1'b0;
    test_reset();
    test_round_robin();
    test_core_stall();
    test_abort();
    test_timeout();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
